// File: rtl/pp_buf_pkg.sv
// Shared helpers for the ring frame buffer: index/count widths and the
// value returned for out-of-range reads.
package pp_buf_pkg;

  // Width of an index into n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter able to hold 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Replicated across the data width for reads beyond the frame.
  localparam logic OOR_FILL = 1'b0;

endpackage

// File: rtl/pp_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port and one registered read port.
// Contents are not reset.
module pp_bank_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1156,
  parameter int unsigned AW     = 11
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/pp_frame_buffer.sv
// N-bank ring frame buffer: a streaming writer fills banks in order, a random-access
// reader consumes completed banks and releases them with i_rd_done.
module pp_frame_buffer
  import pp_buf_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 1156,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NUM_BANKS = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_en,
  input  logic                             i_flush,
  input  logic [DATA_W-1:0]                i_din,
  input  logic                             i_din_vld,
  output logic                             o_wr_ready,
  output logic                             o_overflow,
  input  logic                             i_clr_err,
  input  logic                             i_rd_en,
  input  logic [ADDR_W-1:0]                i_rd_addr,
  output logic [DATA_W-1:0]                o_rd_data,
  output logic                             o_rd_vld,
  input  logic                             i_rd_done,
  output logic                             o_rd_ready,
  output logic [$clog2(NUM_BANKS+1)-1:0]   o_full_cnt
);

  localparam int unsigned BankW = idx_w(NUM_BANKS);
  localparam int unsigned RamAw = idx_w(DEPTH);
  localparam int unsigned CntW  = cnt_w(NUM_BANKS);
  localparam logic [BankW-1:0] LastBank = BankW'(NUM_BANKS - 1);
  localparam logic [RamAw-1:0] LastAddr = RamAw'(DEPTH - 1);

  logic [BankW-1:0]     wr_sel_q, rd_sel_q, rd_bank_q;
  logic [RamAw-1:0]     wr_addr_q;
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic                 overflow_q, rd_vld_q, rd_oor_q;
  logic [DATA_W-1:0]    rd_hold_q;
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
  logic                 wr_fire, wr_last, wr_drop, rd_fire, rd_release, rd_oor;

  function automatic logic [BankW-1:0] ring_next(input logic [BankW-1:0] s);
    return (s == LastBank) ? '0 : s + 1'b1;
  endfunction

  assign o_wr_ready = i_en & ~full_q[wr_sel_q];
  assign o_rd_ready = full_q[rd_sel_q];
  assign o_overflow = overflow_q;
  assign o_rd_vld   = rd_vld_q;

  // Flush takes priority over a same-cycle write; the word is discarded silently.
  assign wr_fire    = i_din_vld & o_wr_ready & ~i_flush;
  assign wr_drop    = i_din_vld & ~o_wr_ready & ~i_flush;
  assign wr_last    = wr_fire & (wr_addr_q == LastAddr);
  assign rd_fire    = i_rd_en & o_rd_ready;
  assign rd_release = i_rd_done & o_rd_ready;
  assign rd_oor     = {1'b0, i_rd_addr} >= (ADDR_W + 1)'(DEPTH);

  // Completion and release always target different banks, so both can apply.
  always_comb begin
    full_d = full_q;
    if (wr_last)    full_d[wr_sel_q] = 1'b1;
    if (rd_release) full_d[rd_sel_q] = 1'b0;
  end

  always_comb begin
    o_full_cnt = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      o_full_cnt = o_full_cnt + CntW'(full_q[b]);
    end
  end

  // Data holds its last value between reads; the bank is the one latched at request time.
  always_comb begin
    o_rd_data = rd_hold_q;
    if (rd_vld_q) o_rd_data = rd_oor_q ? {DATA_W{OOR_FILL}} : bank_rdata[rd_bank_q];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_sel_q   <= '0;
      rd_sel_q   <= '0;
      rd_bank_q  <= '0;
      wr_addr_q  <= '0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      if (i_flush) begin
        wr_addr_q <= '0;
      end else if (wr_last) begin
        wr_addr_q <= '0;
        wr_sel_q  <= ring_next(wr_sel_q);
      end else if (wr_fire) begin
        wr_addr_q <= wr_addr_q + 1'b1;
      end
      if (rd_release) rd_sel_q <= ring_next(rd_sel_q);
      full_q <= full_d;
      if (wr_drop)        overflow_q <= 1'b1;
      else if (i_clr_err) overflow_q <= 1'b0;
      rd_vld_q <= rd_fire;
      if (rd_fire) begin
        rd_bank_q <= rd_sel_q;
        rd_oor_q  <= rd_oor;
      end
      rd_hold_q <= o_rd_data;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    pp_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (RamAw)
    ) u_ram (
      .i_clk   (i_clk),
      .i_we    (wr_fire & (wr_sel_q == BankW'(g))),
      .i_waddr (wr_addr_q),
      .i_wdata (i_din),
      .i_re    (rd_fire & ~rd_oor & (rd_sel_q == BankW'(g))),
      .i_raddr (i_rd_addr[RamAw-1:0]),
      .o_rdata (bank_rdata[g])
    );
  end

endmodule

// File: tb/tb_pp_frame_buffer.sv
// Directed bench for pp_frame_buffer: a 2-bank full-size instance and a small 3-bank
// instance used to check ring rotation.
module tb_pp_frame_buffer;

  localparam int unsigned DEP  = 1156;
  localparam int unsigned AW   = 16;
  localparam int unsigned DEP3 = 4;
  localparam int unsigned AW3  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          en, flush, din_vld, clr_err, rd_en, rd_done;
  logic [7:0]    din;
  logic [AW-1:0] rd_addr;
  logic          wr_ready, overflow, rd_vld, rd_ready;
  logic [7:0]    rd_data;
  logic [1:0]    full_cnt;

  logic           en3, flush3, din_vld3, clr_err3, rd_en3, rd_done3;
  logic [7:0]     din3;
  logic [AW3-1:0] rd_addr3;
  logic           wr_ready3, overflow3, rd_vld3, rd_ready3;
  logic [7:0]     rd_data3;
  logic [1:0]     full_cnt3;

  int checks   = 0;
  int failures = 0;

  pp_frame_buffer #(
    .DATA_W    (8),
    .DEPTH     (DEP),
    .ADDR_W    (AW),
    .NUM_BANKS (2)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_flush    (flush),
    .i_din      (din),
    .i_din_vld  (din_vld),
    .o_wr_ready (wr_ready),
    .o_overflow (overflow),
    .i_clr_err  (clr_err),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_rd_vld   (rd_vld),
    .i_rd_done  (rd_done),
    .o_rd_ready (rd_ready),
    .o_full_cnt (full_cnt)
  );

  pp_frame_buffer #(
    .DATA_W    (8),
    .DEPTH     (DEP3),
    .ADDR_W    (AW3),
    .NUM_BANKS (3)
  ) u_dut3 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en3),
    .i_flush    (flush3),
    .i_din      (din3),
    .i_din_vld  (din_vld3),
    .o_wr_ready (wr_ready3),
    .o_overflow (overflow3),
    .i_clr_err  (clr_err3),
    .i_rd_en    (rd_en3),
    .i_rd_addr  (rd_addr3),
    .o_rd_data  (rd_data3),
    .o_rd_vld   (rd_vld3),
    .i_rd_done  (rd_done3),
    .o_rd_ready (rd_ready3),
    .o_full_cnt (full_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input logic [7:0] val, input int n);
    din     = val;
    din_vld = 1'b1;
    repeat (n) tick();
    din_vld = 1'b0;
  endtask

  task automatic read1(input int addr);
    rd_addr = AW'(addr);
    rd_en   = 1'b1;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic write3(input logic [7:0] val);
    din3     = val;
    din_vld3 = 1'b1;
    repeat (DEP3) tick();
    din_vld3 = 1'b0;
  endtask

  task automatic read3(input int addr);
    rd_addr3 = AW3'(addr);
    rd_en3   = 1'b1;
    tick();
    rd_en3   = 1'b0;
  endtask

  int bad;

  initial begin
    rst_n = 1'b0;
    en = 1'b0; flush = 1'b0; din = '0; din_vld = 1'b0; clr_err = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    en3 = 1'b1; flush3 = 1'b0; din3 = '0; din_vld3 = 1'b0; clr_err3 = 1'b0;
    rd_en3 = 1'b0; rd_addr3 = '0; rd_done3 = 1'b0;
    #12;
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_rd_ready", 32'(rd_ready), 0);
    check("rst_full_cnt", 32'(full_cnt), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_rd_vld", 32'(rd_vld), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    #1;
    check("en_wr_ready", 32'(wr_ready), 1);

    // Frame of 8 into bank0
    write_words(8'd8, DEP - 1);
    check("t1_no_early_rd_ready", 32'(rd_ready), 0);
    write_words(8'd8, 1);
    check("t1_rd_ready", 32'(rd_ready), 1);
    check("t1_full_cnt", 32'(full_cnt), 1);
    check("t1_wr_ready_bank1", 32'(wr_ready), 1);
    read1(1155);
    check("t1_rd_vld", 32'(rd_vld), 1);
    check("t1_rd_data", 32'(rd_data), 8);
    tick();
    check("t1_rd_vld_drop", 32'(rd_vld), 0);
    check("t1_rd_data_hold", 32'(rd_data), 8);

    // Fill bank1 with 7; writer then blocked on bank0
    write_words(8'd7, DEP);
    check("t2_full_cnt", 32'(full_cnt), 2);
    check("t2_wr_blocked", 32'(wr_ready), 0);
    write_words(8'd9, 1);
    check("t2_overflow", 32'(overflow), 1);
    read1(0);
    check("t2_bank0_intact", 32'(rd_data), 8);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t2_overflow_clr", 32'(overflow), 0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("t2_wr_ready_after_done", 32'(wr_ready), 1);
    check("t2_rd_ready_bank1", 32'(rd_ready), 1);
    check("t2_full_cnt_after_done", 32'(full_cnt), 1);
    read1(500);
    check("t2_bank1_data", 32'(rd_data), 7);
    read1(2000);
    check("t5_oor_vld", 32'(rd_vld), 1);
    check("t5_oor_data", 32'(rd_data), 0);

    // Partial frame, flush with a colliding write, then a full frame of 6
    write_words(8'd5, 600);
    din = 8'd5; din_vld = 1'b1; flush = 1'b1;
    tick();
    din_vld = 1'b0; flush = 1'b0;
    check("t3_flush_no_overflow", 32'(overflow), 0);
    write_words(8'd6, DEP - 1);
    check("t3_no_early_full", 32'(full_cnt), 1);
    din = 8'd6; din_vld = 1'b1; rd_done = 1'b1;
    tick();
    din_vld = 1'b0; rd_done = 1'b0;
    check("t4_full_cnt_net", 32'(full_cnt), 1);
    check("t4_rd_ready_bank0", 32'(rd_ready), 1);
    check("t4_wr_ready_bank1", 32'(wr_ready), 1);
    bad   = 0;
    rd_en = 1'b1;
    for (int a = 0; a < DEP; a++) begin
      rd_addr = AW'(a);
      tick();
      if (rd_data !== 8'd6 || rd_vld !== 1'b1) bad++;
    end
    rd_en = 1'b0;
    check("t3_bank0_all6_bad", 32'(bad), 0);

    // Release bank0; bank1 empty so reads are refused
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("t5_rd_ready_empty", 32'(rd_ready), 0);
    check("t5_full_cnt_zero", 32'(full_cnt), 0);
    read1(3);
    check("t5_refused_vld", 32'(rd_vld), 0);
    check("t5_refused_hold", 32'(rd_data), 6);

    // Build up state, then reset asynchronously mid-cycle
    en = 1'b0; din_vld = 1'b1;
    #1;
    check("t6_disabled_wr_ready", 32'(wr_ready), 0);
    tick();
    din_vld = 1'b0; en = 1'b1;
    check("t6_overflow_disabled", 32'(overflow), 1);
    write_words(8'd3, DEP);
    write_words(8'd2, 300);
    rd_addr = AW'(10);
    rd_en   = 1'b1;
    tick();
    check("t6_pre_rst_vld", 32'(rd_vld), 1);
    check("t6_pre_rst_data", 32'(rd_data), 3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_rd_vld", 32'(rd_vld), 0);
    check("t6_async_rd_data", 32'(rd_data), 0);
    check("t6_async_rd_ready", 32'(rd_ready), 0);
    check("t6_async_full_cnt", 32'(full_cnt), 0);
    check("t6_async_overflow", 32'(overflow), 0);
    check("t6_async_wr_ready", 32'(wr_ready), 1);
    rd_en = 1'b0;
    rst_n = 1'b1;
    tick();
    write_words(8'd4, DEP - 1);
    check("t6_post_no_early", 32'(rd_ready), 0);
    write_words(8'd4, 1);
    check("t6_post_rd_ready", 32'(rd_ready), 1);
    read1(0);
    check("t6_post_data", 32'(rd_data), 4);

    // Three-bank ring: 0 -> 1 -> 2 -> 0
    write3(8'd1);
    check("r3_cnt1", 32'(full_cnt3), 1);
    write3(8'd2);
    check("r3_cnt2", 32'(full_cnt3), 2);
    write3(8'd3);
    check("r3_cnt3", 32'(full_cnt3), 3);
    check("r3_wr_blocked", 32'(wr_ready3), 0);
    read3(3);
    check("r3_bank0", 32'(rd_data3), 1);
    rd_done3 = 1'b1;
    tick();
    rd_done3 = 1'b0;
    check("r3_wr_ready_again", 32'(wr_ready3), 1);
    read3(1);
    check("r3_bank1", 32'(rd_data3), 2);
    write3(8'd4);
    check("r3_cnt_refill", 32'(full_cnt3), 3);
    rd_done3 = 1'b1;
    tick();
    rd_done3 = 1'b0;
    read3(2);
    check("r3_bank2", 32'(rd_data3), 3);
    rd_done3 = 1'b1;
    tick();
    rd_done3 = 1'b0;
    read3(0);
    check("r3_wrap_bank0", 32'(rd_data3), 4);
    check("r3_cnt_final", 32'(full_cnt3), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
